// File: rtl/vga_sched_pkg.sv
// Shared definitions for the VGA frame scheduler: state encoding,
// default 640x480 geometry and the pattern-step helper.
package vga_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_RUN      = 2'd2,
    ST_STOPPING = 2'd3
  } state_t;

  localparam int DEF_LINE_VALIDS = 640;
  localparam int DEF_V_ACTIVE    = 480;

  // Next pattern index, wrapping at n (n in 2..16).
  function automatic logic [3:0] pat_next(input logic [3:0] p, input int n);
    return (32'(p) == n - 1) ? 4'd0 : p + 4'd1;
  endfunction

endpackage

// File: rtl/vga_geom_check.sv
// Active-geometry checker: counts in_valid pulses per line and lines per
// frame, and raises a sticky error on any mismatch with the expected size.
// Instantiated only when VGA_FRAME_SCHED_CHECK_EN is defined.
module vga_geom_check #(
  parameter int LINE_VALIDS = 640,
  parameter int V_ACTIVE    = 480,
  parameter int PW          = 14
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,    // accepted start: clears the sticky error
  input  logic sync,   // first boundary of a run: clears counters
  input  logic arm,    // checking enabled (counted frames only)
  input  logic frame,  // counted frame boundary
  input  logic de,
  input  logic valid,
  output logic err
);

  logic          de_d;
  logic          de_fall;
  logic [PW-1:0] pix_cnt;
  logic [PW-1:0] line_cnt;
  logic          pix_bad;
  logic          line_bad;

  assign de_fall  = de_d & ~de;
  assign pix_bad  = arm && de_fall && (pix_cnt != PW'(LINE_VALIDS));
  assign line_bad = arm && frame && (line_cnt != PW'(V_ACTIVE));

  // DE edge detector
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) de_d <= 1'b0;
    else       de_d <= de;
  end

  // Pixel counter: saturating, cleared at each line end and run sync
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                     pix_cnt <= '0;
    else if (sync || de_fall)      pix_cnt <= '0;
    else if (valid && !(&pix_cnt)) pix_cnt <= pix_cnt + PW'(1);
  end

  // Line counter: one per line end, cleared at each counted frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        line_cnt <= '0;
    else if (sync || frame)           line_cnt <= '0;
    else if (de_fall && !(&line_cnt)) line_cnt <= line_cnt + PW'(1);
  end

  // Sticky error; a new run clears it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                    err <= 1'b0;
    else if (clr)                 err <= 1'b0;
    else if (pix_bad || line_bad) err <= 1'b1;
  end

endmodule

// File: rtl/vga_frame_sched.sv
// Frame-level controller for the vga_gen timing generator: holds it in
// reset until started, drops the first partial frame, runs a bounded or
// continuous number of frames and steps a pattern index per frame.
// Optional geometry checker: define VGA_FRAME_SCHED_CHECK_EN.
module vga_frame_sched
  import vga_sched_pkg::*;
#(
  parameter int LINE_VALIDS = DEF_LINE_VALIDS,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int FW          = 16,
  parameter int PAT_NUM     = 4,
  parameter int PW          = 14
) (
  input  logic          in_pclk,
  input  logic          in_rstn,
  input  logic          in_start,
  input  logic          in_stop,
  input  logic [FW-1:0] in_frames,
  input  logic          in_vs,
  input  logic          in_de,
  input  logic          in_valid,
  output logic          out_gen_rstn,
  output logic [3:0]    out_pattern,
  output logic [FW-1:0] out_frame_cnt,
  output logic          out_frame_start,
  output logic          out_busy,
  output logic          out_done,
  output logic          out_err
);

  state_t        state;
  logic          vs_d;
  logic          fb;
  logic [FW-1:0] frames_q;
  logic [FW-1:0] cnt_nxt;
  logic          last;
  logic          start_acc;

  // Frame boundary is the falling edge of active-low VS; the rising edge
  // caused by resetting the generator never fires it.
  assign fb        = vs_d & ~in_vs;
  assign cnt_nxt   = out_frame_cnt + FW'(1);
  assign last      = (frames_q != '0) && (cnt_nxt == frames_q);
  assign start_acc = (state == ST_IDLE) && in_start;

  // VS delay for edge detection
  always_ff @(posedge in_pclk or negedge in_rstn) begin
    if (!in_rstn) vs_d <= 1'b1;
    else          vs_d <= in_vs;
  end

  // Run-control FSM with registered outputs
  always_ff @(posedge in_pclk or negedge in_rstn) begin
    if (!in_rstn) begin
      state           <= ST_IDLE;
      frames_q        <= '0;
      out_gen_rstn    <= 1'b0;
      out_pattern     <= 4'd0;
      out_frame_cnt   <= '0;
      out_frame_start <= 1'b0;
      out_busy        <= 1'b0;
      out_done        <= 1'b0;
    end else begin
      out_frame_start <= 1'b0;
      out_done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          // start wins over a coincident stop; stop alone is ignored
          if (in_start) begin
            state         <= ST_WARMUP;
            frames_q      <= in_frames;
            out_frame_cnt <= '0;
            out_pattern   <= 4'd0;
            out_gen_rstn  <= 1'b1;
            out_busy      <= 1'b1;
          end
        end
        ST_WARMUP: begin
          // the partial first frame only synchronises us to the generator
          if (in_stop) begin
            state        <= ST_IDLE;
            out_done     <= 1'b1;
            out_gen_rstn <= 1'b0;
            out_busy     <= 1'b0;
          end else if (fb) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fb) begin
            out_frame_cnt   <= cnt_nxt;
            out_frame_start <= 1'b1;
            out_pattern     <= pat_next(out_pattern, PAT_NUM);
            // reaching the target ends the run; a coincident stop adds nothing
            if (last) begin
              state        <= ST_IDLE;
              out_done     <= 1'b1;
              out_gen_rstn <= 1'b0;
              out_busy     <= 1'b0;
            end else if (in_stop) begin
              state <= ST_STOPPING;
            end
          end else if (in_stop) begin
            state <= ST_STOPPING;
          end
        end
        ST_STOPPING: begin
          // finish and count the frame in progress, then end the run
          if (fb) begin
            out_frame_cnt   <= cnt_nxt;
            out_frame_start <= 1'b1;
            out_pattern     <= pat_next(out_pattern, PAT_NUM);
            state           <= ST_IDLE;
            out_done        <= 1'b1;
            out_gen_rstn    <= 1'b0;
            out_busy        <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef VGA_FRAME_SCHED_CHECK_EN
  logic chk_arm;
  logic chk_sync;
  logic chk_frame;

  assign chk_arm   = (state == ST_RUN) || (state == ST_STOPPING);
  assign chk_sync  = (state == ST_WARMUP) && fb && !in_stop;
  assign chk_frame = chk_arm && fb;

  vga_geom_check #(
    .LINE_VALIDS (LINE_VALIDS),
    .V_ACTIVE    (V_ACTIVE),
    .PW          (PW)
  ) u_geom (
    .clk   (in_pclk),
    .rstn  (in_rstn),
    .clr   (start_acc),
    .sync  (chk_sync),
    .arm   (chk_arm),
    .frame (chk_frame),
    .de    (in_de),
    .valid (in_valid),
    .err   (out_err)
  );
`else
  // No checker: geometry inputs and parameters are intentionally unused.
  localparam int unused_geom = LINE_VALIDS + V_ACTIVE + PW;
  logic unused_in;
  assign unused_in = ^{in_de, in_valid, start_acc};
  assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_sched.sv
// Directed bench for vga_frame_sched driven by a tiny VGA timing model
// (8 valids x 4 active lines, 12x7 total). A second instance expects one
// valid fewer per line, so its error flag sets when the checker is built.
module tb_vga_frame_sched;
  localparam int LV = 8, VA = 4, FW = 3, PN = 4, PW = 6, HT = 12, VT = 7;
`ifdef VGA_FRAME_SCHED_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0, rstn = 1'b1, start = 1'b0, stop = 1'b0;
  logic [FW-1:0] frames = '0;
  logic gen_rstn, gen_rstn_b, fs, fs_b, busy, busy_b, done, done_b, err, err_b;
  logic [3:0] pat, pat_b;
  logic [FW-1:0] fcnt, fcnt_b;
  logic vs, de, valid;
  int h, v;
  int n_chk = 0, n_fail = 0;
  int fs_tot = 0, done_tot = 0, done_bad = 0;
  logic grst_prev = 1'b0;
  logic [3:0] pat_log [16];

  always #5 clk = ~clk;

  // Generator model, held in reset by the scheduler
  always @(posedge clk or negedge gen_rstn) begin
    if (!gen_rstn) begin h <= 0; v <= 0; end
    else if (h == HT - 1) begin h <= 0; v <= (v == VT - 1) ? 0 : v + 1; end
    else h <= h + 1;
  end
  assign vs    = !(gen_rstn && v == 5);
  assign de    = gen_rstn && (v < VA) && (h < LV);
  assign valid = de;

  vga_frame_sched #(.LINE_VALIDS(LV), .V_ACTIVE(VA), .FW(FW), .PAT_NUM(PN), .PW(PW)) dut (
    .in_pclk(clk), .in_rstn(rstn), .in_start(start), .in_stop(stop), .in_frames(frames),
    .in_vs(vs), .in_de(de), .in_valid(valid), .out_gen_rstn(gen_rstn), .out_pattern(pat),
    .out_frame_cnt(fcnt), .out_frame_start(fs), .out_busy(busy), .out_done(done), .out_err(err));

  vga_frame_sched #(.LINE_VALIDS(LV - 1), .V_ACTIVE(VA), .FW(FW), .PAT_NUM(PN), .PW(PW)) dut_bad (
    .in_pclk(clk), .in_rstn(rstn), .in_start(start), .in_stop(stop), .in_frames(frames),
    .in_vs(vs), .in_de(de), .in_valid(valid), .out_gen_rstn(gen_rstn_b), .out_pattern(pat_b),
    .out_frame_cnt(fcnt_b), .out_frame_start(fs_b), .out_busy(busy_b), .out_done(done_b), .out_err(err_b));

  // Event monitor: frame pulses with their pattern, done pulses and their
  // coincidence with the generator reset falling
  always @(negedge clk) begin
    if (fs) begin pat_log[fs_tot % 16] = pat; fs_tot++; end
    if (done) begin
      done_tot++;
      if (!(gen_rstn == 1'b0 && grst_prev == 1'b1)) done_bad++;
    end
    grst_prev = gen_rstn;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start(input logic [FW-1:0] f, input logic s);
    start = 1'b1; frames = f; stop = s;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin tick(); k++; end
    chk({tag, "_done_seen"}, 32'(done), 1);
  endtask

  task automatic wait_fs(input string tag, input int base, input int n, input int budget);
    int k = 0;
    while (fs_tot - base < n && k < budget) begin tick(); k++; end
    chk({tag, "_fs_reached"}, 32'(fs_tot - base >= n), 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_gen_rstn"}, 32'(gen_rstn), 0);
    chk({tag, "_pattern"},  32'(pat), 0);
    chk({tag, "_fcnt"},     32'(fcnt), 0);
    chk({tag, "_fs"},       32'(fs), 0);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_done"},     32'(done), 0);
    chk({tag, "_err"},      32'(err), 0);
    chk({tag, "_err_b"},    32'(err_b), 0);
  endtask

  initial begin
    int b_fs, b_d, k;
    #1 rstn = 1'b0;
    repeat (3) tick();
    chk_reset_outs("rst");
    rstn = 1'b1;
    tick();
    chk_reset_outs("idle");

    // 1: bounded run of 3 frames
    b_fs = fs_tot; b_d = done_tot;
    pulse_start(3'd3, 1'b0);
    chk("s1_gen_rstn_up", 32'(gen_rstn), 1);
    chk("s1_busy_up", 32'(busy), 1);
    wait_done("s1", 2000);
    chk("s1_fcnt", 32'(fcnt), 3);
    chk("s1_fs_n", 32'(fs_tot - b_fs), 3);
    for (int i = 0; i < 3; i++) chk("s1_pat_step", 32'(pat_log[(b_fs + i) % 16]), 32'(i + 1));
    chk("s1_gen_rstn_dn", 32'(gen_rstn), 0);
    chk("s1_busy_dn", 32'(busy), 0);
    chk("s1_err", 32'(err), 0);
    chk("s1_err_b", 32'(err_b), 32'(CHK));
    tick();
    chk("s1_done_single", 32'(done_tot - b_d), 1);

    // 2: continuous run, stop mid-frame 5
    b_fs = fs_tot;
    pulse_start(3'd0, 1'b0);
    chk("s2_err_b_clr", 32'(err_b), 0);
    wait_fs("s2", b_fs, 4, 2000);
    repeat (30) tick();
    pulse_stop();
    chk("s2_busy_stopping", 32'(busy), 1);
    wait_done("s2", 2000);
    chk("s2_fcnt", 32'(fcnt), 5);
    chk("s2_pat", 32'(pat), 1);
    chk("s2_fs_n", 32'(fs_tot - b_fs), 5);
    chk("s2_err_b", 32'(err_b), 32'(CHK));

    // 2b: continuous count wraps modulo 2^FW (9 frames -> 1)
    b_fs = fs_tot;
    pulse_start(3'd0, 1'b0);
    wait_fs("wrap", b_fs, 8, 3000);
    repeat (30) tick();
    pulse_stop();
    wait_done("wrap", 2000);
    chk("wrap_fcnt", 32'(fcnt), 1);
    chk("wrap_pat", 32'(pat), 1);

    // 3: stop during warmup
    b_fs = fs_tot;
    pulse_start(3'd0, 1'b0);
    repeat (20) tick();
    pulse_stop();
    chk("s3_done", 32'(done), 1);
    chk("s3_busy", 32'(busy), 0);
    chk("s3_gen_rstn", 32'(gen_rstn), 0);
    chk("s3_fcnt", 32'(fcnt), 0);
    chk("s3_fs_n", 32'(fs_tot - b_fs), 0);

    // 4a: start and stop together in IDLE
    pulse_start(3'd1, 1'b1);
    chk("s4a_busy", 32'(busy), 1);
    wait_done("s4a", 2000);
    chk("s4a_fcnt", 32'(fcnt), 1);

    // 4b: stop coincident with the final boundary
    tick();
    b_fs = fs_tot; b_d = done_tot;
    pulse_start(3'd2, 1'b0);
    wait_fs("s4b", b_fs, 1, 2000);
    k = 0;
    while (!vs && k < 200) begin tick(); k++; end
    while (vs && k < 400) begin tick(); k++; end
    chk("s4b_vs_low", 32'(vs), 0);
    pulse_stop();
    chk("s4b_done_now", 32'(done), 1);
    repeat (150) tick();
    chk("s4b_done_once", 32'(done_tot - b_d), 1);
    chk("s4b_fcnt", 32'(fcnt), 2);

    // 4c: start while busy is ignored
    b_fs = fs_tot;
    pulse_start(3'd2, 1'b0);
    wait_fs("s4c", b_fs, 1, 2000);
    repeat (5) tick();
    pulse_start(3'd7, 1'b0);
    chk("s4c_busy", 32'(busy), 1);
    chk("s4c_fcnt_kept", 32'(fcnt), 1);
    wait_done("s4c", 2000);
    chk("s4c_fcnt", 32'(fcnt), 2);

    // 6: asynchronous reset during frame 2
    b_fs = fs_tot;
    pulse_start(3'd0, 1'b0);
    wait_fs("s6", b_fs, 1, 2000);
    repeat (20) tick();
    b_d = done_tot;
    #2 rstn = 1'b0;
    #1;
    chk_reset_outs("s6_async");
    repeat (3) tick();
    chk("s6_no_done", 32'(done_tot - b_d), 0);
    rstn = 1'b1;
    tick();
    pulse_start(3'd2, 1'b0);
    wait_done("s6_rerun", 2000);
    chk("s6_fcnt", 32'(fcnt), 2);
    chk("s6_pat", 32'(pat), 2);
    chk("done_vs_gen_rstn", 32'(done_bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
